// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: runs a WIDTH-bit AND/OR/ADD/SUB through an external
// 1-bit ALU slice, one bit per clock, LSB first. The carry between bits is
// registered here, and the result is assembled in a shift register.
// Flags are registered when the operation finishes.
module bit_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             err,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_binvert,
  output logic             slice_carry_in,
  output logic [2:0]       slice_operation,
  input  logic             slice_result,
  input  logic             slice_carry_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_res_sr;
  logic [2:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_carry_out, r_overflow, r_err;

  logic             w_legal, w_last, w_arith;
  logic [WIDTH-1:0] w_res_next;

  assign w_legal    = (op == 3'b000) || (op == 3'b001) ||
                      (op == 3'b010) || (op == 3'b110);
  assign w_last     = (r_count == CW'(WIDTH - 1));
  assign w_arith    = r_op[1];
  assign w_res_next = {slice_result, r_res_sr[WIDTH-1:1]};

  assign result    = r_result;
  assign zero      = r_zero;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign err       = r_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; illegal ops skip RUN and report immediately
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_legal ? S_RUN : S_DONE;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake and slice drive; the slice sees zeros outside RUN
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    slice_a         = 1'b0;
    slice_b         = 1'b0;
    slice_binvert   = 1'b0;
    slice_carry_in  = 1'b0;
    slice_operation = '0;
    case (r_state)
      S_RUN: begin
        busy            = 1'b1;
        slice_a         = r_a_sr[0];
        slice_b         = r_b_sr[0];
        slice_binvert   = r_op[2];
        slice_carry_in  = r_carry;
        slice_operation = r_op;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand/result shifting, carry chain, and flag capture on the MSB edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_res_sr    <= '0;
      r_op        <= '0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_a_sr   <= a;
              r_b_sr   <= b;
              r_res_sr <= '0;
              r_op     <= op;
              r_carry  <= op[2];
              r_count  <= '0;
            end else begin
              r_result    <= '0;
              r_zero      <= 1'b1;
              r_carry_out <= 1'b0;
              r_overflow  <= 1'b0;
              r_err       <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_res_sr <= w_res_next;
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_carry  <= slice_carry_out;
          r_count  <= w_last ? '0 : r_count + 1'b1;
          if (w_last) begin
            r_result    <= w_res_next;
            r_zero      <= (w_res_next == '0);
            r_carry_out <= w_arith & slice_carry_out;
            r_overflow  <= w_arith & (r_carry ^ slice_carry_out);
            r_err       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq: models the 1-bit slice, then checks each
// operation against a whole-word arithmetic reference.
module tb_bit_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, zero, carry_out, overflow, err;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_binvert, slice_carry_in;
  logic [2:0]   slice_operation;
  logic         slice_result, slice_carry_out;
  logic         w_bb;

  int n_checks = 0;
  int n_errs   = 0;

  // Displayed-value model (what the outputs should currently hold)
  logic [W-1:0] exp_res = '0;
  logic         exp_z = 1'b0, exp_c = 1'b0, exp_v = 1'b0, exp_e = 1'b0;

  always #5 clk = ~clk;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry_out(carry_out), .overflow(overflow), .err(err),
    .slice_a(slice_a), .slice_b(slice_b), .slice_binvert(slice_binvert),
    .slice_carry_in(slice_carry_in), .slice_operation(slice_operation),
    .slice_result(slice_result), .slice_carry_out(slice_carry_out)
  );

  // The team's 1-bit ALU slice
  assign w_bb            = slice_b ^ slice_binvert;
  assign slice_result    = (slice_operation[1:0] == 2'b00) ? (slice_a & w_bb) :
                           (slice_operation[1:0] == 2'b01) ? (slice_a | w_bb) :
                           (slice_a ^ w_bb ^ slice_carry_in);
  assign slice_carry_out = (slice_a & w_bb) | (slice_a & slice_carry_in) |
                           (w_bb & slice_carry_in);

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] r,
                                output logic z, c, v, e);
    logic [W:0] s;
    c = 1'b0; v = 1'b0; e = 1'b0; r = '0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      default: begin r = '0; e = 1'b1; end
    endcase
    z = (r == '0);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, W'(busy), 0);
    chk({tag, "_done"}, W'(done), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flags"}, W'({zero, carry_out, overflow, err}), 0);
    chk({tag, "_slice"}, W'({slice_a, slice_b, slice_binvert, slice_carry_in, slice_operation}), 0);
  endtask

  // One operation: pulse_at >= 0 pulses start again that many cycles into RUN
  task automatic run_op(input logic [2:0] t_op, input logic [W-1:0] t_a, t_b,
                        input int pulse_at);
    logic [W-1:0] r;
    logic z, c, v, e;
    int edges, busy_cnt;
    model(t_op, t_a, t_b, r, z, c, v, e);
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    edges = 0; busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cnt++;
      if (!e && edges == 1) begin
        chk("held_prev_result", result, exp_res);
        chk("slice_ctl", W'({slice_binvert, slice_operation}), W'({t_op[2], t_op}));
      end
      start = (edges == pulse_at);
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk("latency", W'(edges), e ? 0 : W);
    chk("busy_cycles", W'(busy_cnt), e ? 0 : W);
    chk("result", result, r);
    chk("zero", W'(zero), W'(z));
    chk("carry_out", W'(carry_out), W'(c));
    chk("overflow", W'(overflow), W'(v));
    chk("err", W'(err), W'(e));
    exp_res = r; exp_z = z; exp_c = c; exp_v = v; exp_e = e;
    @(posedge clk); #1;
    chk("done_strobe", W'({done, busy}), 0);
    chk("result_hold", result, exp_res);
    chk("flags_hold", W'({zero, carry_out, overflow, err}), W'({exp_z, exp_c, exp_v, exp_e}));
    chk("slice_idle", W'({slice_a, slice_b, slice_binvert, slice_carry_in, slice_operation}), 0);
  endtask

  task automatic reset_mid_run;
    int edges;
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = $urandom; b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0;
    while (edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_in_reset", W'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_res = '0; exp_z = 1'b0; exp_c = 1'b0; exp_v = 1'b0; exp_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_reset", W'({done, busy}), 0);
    end
  endtask

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b110; ops[4] = 3'b011;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'b010, 32'd5, 32'd3, -1);
    run_op(3'b110, 32'd7, 32'd7, -1);
    run_op(3'b110, 32'd3, 32'd5, -1);
    run_op(3'b010, 32'h7FFF_FFFF, 32'd1, -1);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd1, -1);
    run_op(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);
    run_op(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);
    run_op(3'b011, 32'd9, 32'd4, -1);
    run_op(3'b010, 32'd1, 32'd1, -1);
    run_op(3'b110, 32'h8000_0000, 32'd1, 5);
    reset_mid_run();
    run_op(3'b110, 32'd100, 32'd58, -1);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
      run_op(ops[$urandom_range(0, 4)], ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
